// File: rtl/packet_classifier.sv
// rtl/packet_classifier.sv - serial sync hunter, packet field extractor and rule-table classifier
module packet_classifier #(
    parameter int                SYNC_W   = 32,
    parameter logic [SYNC_W-1:0] SYNC     = 32'hA5A5A5A5,
    parameter int                PKT_BITS = 256,
    parameter int                PORT_OFS = 64,
    parameter int                SESS_OFS = 136,
    parameter int                NUM_CH   = 8,
    parameter int                CNT_W    = 8,
    parameter int                TOT_W    = 32,
    localparam int               IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      data_in,
    input  logic                      data_valid,
    input  logic                      cfg_we,
    input  logic [IDX_W-1:0]          cfg_idx,
    input  logic [15:0]               cfg_port,
    input  logic                      cfg_en,
    input  logic                      clr_cnt,
    output logic [TOT_W-1:0]          total_cnt,
    output logic [TOT_W-1:0]          miss_cnt,
    output logic [NUM_CH*CNT_W-1:0]   pkt_cnt,
    output logic [NUM_CH*CNT_W-1:0]   sess_cnt,
    output logic                      pkt_done,
    output logic [15:0]               pkt_port,
    output logic [NUM_CH-1:0]         pkt_hit
);

    localparam int              BC_W     = $clog2(PKT_BITS + 1);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(PKT_BITS - 1);
    localparam logic [BC_W-1:0] PORT_LO  = BC_W'(PORT_OFS);
    localparam logic [BC_W-1:0] PORT_HI  = BC_W'(PORT_OFS + 16);
    localparam logic [BC_W-1:0] SESS_LO  = BC_W'(SESS_OFS);
    localparam logic [BC_W-1:0] SESS_HI  = BC_W'(SESS_OFS + 8);

    typedef enum logic [1:0] {HUNT, CAPTURE, CLASSIFY} state_t;

    state_t            state_q, state_d;
    logic [SYNC_W-1:0] sync_q, sync_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [15:0]       port_q;
    logic [7:0]        sess_q;

    logic [15:0]       rule_port_q [NUM_CH];
    logic [NUM_CH-1:0] rule_en_q;
    logic [NUM_CH-1:0] seen_q;
    logic [7:0]        last_sess_q [NUM_CH];
    logic [CNT_W-1:0]  pkt_cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  sess_cnt_q  [NUM_CH];
    logic [TOT_W-1:0]  total_q, miss_q;

    logic              pkt_done_q;
    logic [15:0]       pkt_port_q;
    logic [NUM_CH-1:0] pkt_hit_q;

    logic              classify, in_port, in_sess;
    logic              hit_any, sess_new;
    logic [IDX_W-1:0]  win_idx;
    logic [NUM_CH-1:0] hit_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HUNT;
            sync_q    <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sync_d    = sync_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            HUNT: begin
                if (data_valid) begin
                    sync_d = {sync_q[SYNC_W-2:0], data_in};
                    if (sync_d == SYNC) begin
                        state_d   = CAPTURE;
                        bit_cnt_d = '0;
                    end
                end
            end
            CAPTURE: begin
                if (data_valid) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) state_d = CLASSIFY;
                end
            end
            CLASSIFY: begin
                // The bit offered in this cycle is dropped; hunting restarts from a clean register.
                state_d = HUNT;
                sync_d  = '0;
            end
            default: state_d = HUNT;
        endcase
    end

    assign classify = (state_q == CLASSIFY);
    assign in_port  = (state_q == CAPTURE) && data_valid && (bit_cnt_q >= PORT_LO) && (bit_cnt_q < PORT_HI);
    assign in_sess  = (state_q == CAPTURE) && data_valid && (bit_cnt_q >= SESS_LO) && (bit_cnt_q < SESS_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            port_q <= '0;
            sess_q <= '0;
        end else begin
            if (in_port) port_q <= {port_q[14:0], data_in};
            if (in_sess) sess_q <= {sess_q[6:0], data_in};
        end
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        win_idx = '0;
        hit_vec = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rule_en_q[i] && (rule_port_q[i] == port_q)) begin
                hit_any = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
        if (hit_any) hit_vec[win_idx] = 1'b1;
        sess_new = !seen_q[win_idx] || (sess_q > last_sess_q[win_idx]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total_q    <= '0;
            miss_q     <= '0;
            rule_en_q  <= '0;
            seen_q     <= '0;
            pkt_done_q <= 1'b0;
            pkt_port_q <= '0;
            pkt_hit_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                rule_port_q[i] <= '0;
                last_sess_q[i] <= '0;
                pkt_cnt_q[i]   <= '0;
                sess_cnt_q[i]  <= '0;
            end
        end else begin
            pkt_done_q <= classify;
            if (classify) begin
                pkt_port_q <= port_q;
                pkt_hit_q  <= hit_vec;
            end
            if (clr_cnt) begin
                total_q <= '0;
                miss_q  <= '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    pkt_cnt_q[i]  <= '0;
                    sess_cnt_q[i] <= '0;
                end
            end else if (classify) begin
                if (total_q != '1) total_q <= total_q + 1'b1;
                if (hit_any) begin
                    if (pkt_cnt_q[win_idx] != '1) pkt_cnt_q[win_idx] <= pkt_cnt_q[win_idx] + 1'b1;
                    if (sess_new) begin
                        if (sess_cnt_q[win_idx] != '1) sess_cnt_q[win_idx] <= sess_cnt_q[win_idx] + 1'b1;
                        last_sess_q[win_idx] <= sess_q;
                        seen_q[win_idx]      <= 1'b1;
                    end
                end else if (miss_q != '1) begin
                    miss_q <= miss_q + 1'b1;
                end
            end
            // A rule write overrides any same-cycle session update on that channel.
            if (cfg_we) begin
                rule_port_q[cfg_idx] <= cfg_port;
                rule_en_q[cfg_idx]   <= cfg_en;
                seen_q[cfg_idx]      <= 1'b0;
                last_sess_q[cfg_idx] <= '0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign pkt_cnt[g*CNT_W +: CNT_W]  = pkt_cnt_q[g];
        assign sess_cnt[g*CNT_W +: CNT_W] = sess_cnt_q[g];
    end

    assign total_cnt = total_q;
    assign miss_cnt  = miss_q;
    assign pkt_done  = pkt_done_q;
    assign pkt_port  = pkt_port_q;
    assign pkt_hit   = pkt_hit_q;

endmodule

// File: tb/tb_packet_classifier.sv
// tb/tb_packet_classifier.sv - bench for packet_classifier: vector table, scoreboard and corner sequences
module tb_packet_classifier;
    localparam int NUM_CH = 8, CNT_W = 8, TOT_W = 32, PKT_BITS = 256, SYNC_W = 32;
    localparam int PORT_OFS = 64, SESS_OFS = 136;
    localparam logic [31:0] SYNC_WORD = 32'hA5A5A5A5;

    logic clk = 1'b0;
    logic rst, data_in, data_valid, cfg_we, cfg_en, clr_cnt;
    logic [2:0]  cfg_idx;
    logic [15:0] cfg_port;
    logic [TOT_W-1:0] total_cnt, miss_cnt;
    logic [NUM_CH*CNT_W-1:0] pkt_cnt, sess_cnt;
    logic pkt_done;
    logic [15:0] pkt_port;
    logic [NUM_CH-1:0] pkt_hit;

    packet_classifier #(
        .SYNC_W(SYNC_W), .SYNC(SYNC_WORD), .PKT_BITS(PKT_BITS), .PORT_OFS(PORT_OFS),
        .SESS_OFS(SESS_OFS), .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TOT_W(TOT_W)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_port(cfg_port), .cfg_en(cfg_en),
        .clr_cnt(clr_cnt), .total_cnt(total_cnt), .miss_cnt(miss_cnt),
        .pkt_cnt(pkt_cnt), .sess_cnt(sess_cnt), .pkt_done(pkt_done),
        .pkt_port(pkt_port), .pkt_hit(pkt_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] port;
        logic [7:0]  sess;
        logic [7:0]  hit;
        longint      total;
        longint      miss;
        int          ch;
        int          ch_pkt;
        int          ch_sess;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0, n_bad = 0;

    logic [15:0] m_port [NUM_CH];
    bit          m_en   [NUM_CH];
    bit          m_seen [NUM_CH];
    int          m_last [NUM_CH];
    int          m_pkt  [NUM_CH];
    int          m_sess [NUM_CH];
    longint      m_total, m_miss;

    task automatic chk(string name, longint act, longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_port[i] = '0; m_en[i] = 0; m_seen[i] = 0; m_last[i] = 0; m_pkt[i] = 0; m_sess[i] = 0;
        end
        m_total = 0; m_miss = 0;
    endfunction

    function automatic void model_rule(int idx, logic [15:0] port, bit en);
        m_port[idx] = port; m_en[idx] = en; m_seen[idx] = 0; m_last[idx] = 0;
    endfunction

    function automatic exp_t model_pkt(logic [15:0] port, logic [7:0] sess, bit clr);
        exp_t e;
        int w = -1;
        for (int i = 0; i < NUM_CH; i++)
            if (w < 0 && m_en[i] && m_port[i] == port) w = i;
        e.port = port; e.sess = sess;
        e.hit = (w < 0) ? 8'h00 : 8'(1 << w);
        if (clr) begin
            m_total = 0; m_miss = 0;
            for (int i = 0; i < NUM_CH; i++) begin m_pkt[i] = 0; m_sess[i] = 0; end
        end else begin
            m_total++;
            if (w < 0) m_miss++;
            else begin
                if (m_pkt[w] < 255) m_pkt[w]++;
                if (!m_seen[w] || int'(sess) > m_last[w]) begin
                    if (m_sess[w] < 255) m_sess[w]++;
                    m_last[w] = int'(sess); m_seen[w] = 1;
                end
            end
        end
        e.total = m_total; e.miss = m_miss;
        e.ch = (w < 0) ? 0 : w;
        e.ch_pkt = m_pkt[e.ch]; e.ch_sess = m_sess[e.ch];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(logic b);
        data_in = b; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic write_rule(int idx, logic [15:0] port, bit en);
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_port = port; cfg_en = en;
        tick();
        cfg_we = 1'b0;
        model_rule(idx, port, en);
    endtask

    task automatic send_sync();
        logic [31:0] s;
        s = SYNC_WORD;
        for (int i = 31; i >= 0; i--) send_bit(s[i]);
    endtask

    // Sends sync + packet; the expectation must already be queued. cfg_ch >= 0 writes that rule during CLASSIFY.
    task automatic send_packet(logic [15:0] port, logic [7:0] sess, int gap_at, bit embed,
                               bit clr_at_cls, int cfg_ch, logic [15:0] cfg_p, bit cfg_e);
        logic [PKT_BITS-1:0] p;
        logic [31:0] s;
        bit early;
        exp_t e;
        s = SYNC_WORD;
        early = 0;
        for (int k = 0; k < PKT_BITS; k++) p[k] = 1'($urandom_range(0, 1));
        if (embed) for (int j = 0; j < 32; j++) p[100 + j] = s[31 - j];
        for (int j = 0; j < 16; j++) p[PORT_OFS + j] = port[15 - j];
        for (int j = 0; j < 8; j++)  p[SESS_OFS + j] = sess[7 - j];
        for (int i = 31; i >= 0; i--) begin
            send_bit(s[i]);
            if (pkt_done) early = 1;
        end
        for (int k = 0; k < PKT_BITS; k++) begin
            if (k == gap_at) begin
                for (int g = 0; g < 10; g++) begin
                    data_in = 1'($urandom_range(0, 1));
                    tick();
                    if (pkt_done) early = 1;
                end
            end
            send_bit(p[k]);
            if (pkt_done) early = 1;
        end
        chk("no_early_done", longint'(early), 0);
        data_in = 1'b1;
        data_valid = 1'b1;
        clr_cnt = clr_at_cls;
        if (cfg_ch >= 0) begin
            cfg_we = 1'b1; cfg_idx = 3'(cfg_ch); cfg_port = cfg_p; cfg_en = cfg_e;
        end
        tick();
        data_valid = 1'b0; clr_cnt = 1'b0; cfg_we = 1'b0;
        chk("pkt_done_pulse", longint'(pkt_done), 1);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("pkt_port", longint'(pkt_port), longint'(e.port));
            chk("pkt_hit", longint'(pkt_hit), longint'(e.hit));
            chk("total_cnt", longint'(total_cnt), e.total);
            chk("miss_cnt", longint'(miss_cnt), e.miss);
            chk("pkt_cnt_ch", longint'(pkt_cnt[e.ch*CNT_W +: CNT_W]), longint'(e.ch_pkt));
            chk("sess_cnt_ch", longint'(sess_cnt[e.ch*CNT_W +: CNT_W]), longint'(e.ch_sess));
        end
        tick();
        chk("pkt_done_width", longint'(pkt_done), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        exp_t tbl[6];
        exp_t e;
        tbl[0] = '{16'd23399, 8'd5, 8'h01, 1, 0, 0, 1, 1};
        tbl[1] = '{16'd22,    8'd7, 8'h04, 2, 0, 2, 1, 1};
        tbl[2] = '{16'd80,    8'd1, 8'h00, 3, 1, 0, 1, 1};
        tbl[3] = '{16'd23399, 8'd5, 8'h01, 4, 1, 0, 2, 1};
        tbl[4] = '{16'd23399, 8'd3, 8'h01, 5, 1, 0, 3, 1};
        tbl[5] = '{16'd23399, 8'd9, 8'h01, 6, 1, 0, 4, 2};

        rst = 1'b1; data_in = 1'b0; data_valid = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_port = '0; cfg_en = 1'b0; clr_cnt = 1'b0;
        do_reset();
        chk("rst_total", longint'(total_cnt), 0);
        chk("rst_miss", longint'(miss_cnt), 0);
        chk("rst_pkt_cnt", longint'(pkt_cnt), 0);
        chk("rst_sess_cnt", longint'(sess_cnt), 0);
        chk("rst_pkt_done", longint'(pkt_done), 0);
        chk("rst_pkt_hit", longint'(pkt_hit), 0);
        chk("rst_pkt_port", longint'(pkt_port), 0);

        write_rule(0, 16'd23399, 1);
        write_rule(2, 16'd22, 1);
        write_rule(5, 16'd22, 1);
        for (int i = 0; i < 6; i++) begin
            e = model_pkt(tbl[i].port, tbl[i].sess, 0);
            sb.push_back(tbl[i]);
            send_packet(tbl[i].port, tbl[i].sess, -1, 0, 0, -1, 16'd0, 0);
        end
        chk("ch5_untouched", longint'(pkt_cnt[5*CNT_W +: CNT_W]), 0);

        // Rewriting a rule forgets the session history but keeps counters.
        write_rule(0, 16'd23399, 1);
        e = model_pkt(16'd23399, 8'd1, 0);
        sb.push_back('{16'd23399, 8'd1, 8'h01, 7, 1, 0, 5, 3});
        send_packet(16'd23399, 8'd1, -1, 0, 0, -1, 16'd0, 0);

        sb.push_back(model_pkt(16'd22, 8'd7, 0));
        send_packet(16'd22, 8'd7, 50, 0, 0, -1, 16'd0, 0);

        sb.push_back(model_pkt(16'd80, 8'd2, 0));
        send_packet(16'd80, 8'd2, -1, 1, 0, -1, 16'd0, 0);

        sb.push_back(model_pkt(16'd23399, 8'd20, 1));
        send_packet(16'd23399, 8'd20, -1, 0, 1, -1, 16'd0, 0);
        chk("clr_pkt_cnt_all", longint'(pkt_cnt), 0);
        chk("clr_sess_cnt_all", longint'(sess_cnt), 0);

        sb.push_back(model_pkt(16'd22, 8'd40, 0));
        send_packet(16'd22, 8'd40, -1, 0, 0, 2, 16'd22, 0);
        model_rule(2, 16'd22, 0);
        sb.push_back(model_pkt(16'd22, 8'd41, 0));
        send_packet(16'd22, 8'd41, -1, 0, 0, -1, 16'd0, 0);

        send_sync();
        for (int k = 0; k < 100; k++) send_bit(1'($urandom_range(0, 1)));
        do_reset();
        chk("midrst_total", longint'(total_cnt), 0);
        chk("midrst_pkt_hit", longint'(pkt_hit), 0);
        sb.push_back(model_pkt(16'd23399, 8'd3, 0));
        send_packet(16'd23399, 8'd3, -1, 0, 0, -1, 16'd0, 0);
        chk("after_rst_total", longint'(total_cnt), 1);

        do_reset();
        write_rule(0, 16'd23399, 1);
        for (int i = 0; i < 260; i++) begin
            sb.push_back(model_pkt(16'd23399, 8'(i), 0));
            send_packet(16'd23399, 8'(i), -1, 0, 0, -1, 16'd0, 0);
        end
        chk("sat_pkt_cnt0", longint'(pkt_cnt[0 +: CNT_W]), 255);
        chk("sat_total", longint'(total_cnt), 260);
        chk("sb_drained", longint'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/packet_classifier.md
# packet_classifier

Parametrised serial packet classifier, successor to the fixed-port inspector. It hunts a serial bit stream for a sync word, then captures a fixed-length packet and extracts a 16-bit port field and an 8-bit session field. It matches the port against a runtime-programmable rule table of NUM_CH channels and keeps saturating per-channel packet and session counters, plus total and miss counters. It sits directly behind the serial line receiver and feeds the statistics readout.

## Interface
- SYNC, 32'hA5A5A5A5: sync word, compared MSB-first
- SYNC_W, 32: sync word width
- PKT_BITS, 256: packet length in bits after the sync word (≥ SESS_OFS+8 and ≥ PORT_OFS+16)
- PORT_OFS, 64: bit ordinal of the port field's first received bit (port MSB)
- SESS_OFS, 136: bit ordinal of the session field's first received bit (session MSB)
- NUM_CH, 8: rule/counter channels
- CNT_W, 8: per-channel counter width
- TOT_W, 32: total_cnt and miss_cnt width

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- data_in  in  1  serial bit
- data_valid  in  1  data_in is sampled only when high
- cfg_we  in  1  rule write strobe
- cfg_idx  in  $clog2(NUM_CH)  rule index
- cfg_port  in  16  port value to match
- cfg_en  in  1  rule enable
- clr_cnt  in  1  clears all counters; rules and session state are kept
- total_cnt  out  TOT_W  packets classified
- miss_cnt  out  TOT_W  packets matching no enabled rule
- pkt_cnt  out  NUM_CH*CNT_W  per-channel hits; channel i at [i*CNT_W +: CNT_W]
- sess_cnt  out  NUM_CH*CNT_W  per-channel new-session count, same packing
- pkt_done  out  1  one-cycle pulse per classified packet
- pkt_port  out  16  port field of the last classified packet
- pkt_hit  out  NUM_CH  one-hot winning channel of the last packet; 0 means miss

## Operation
- The FSM has three states: HUNT, CAPTURE and CLASSIFY.
- HUNT:
  - Each valid bit shifts into the SYNC_W-bit sync register (new bit at LSB).
  - When the register, including the bit just shifted in, equals SYNC, the FSM moves to CAPTURE and the bit counter is set to 0.
- CAPTURE:
  - Each valid bit is stored at ordinal = bit counter, and the counter increments.
  - On the valid bit with ordinal PKT_BITS-1, the FSM moves to CLASSIFY.
  - Invalid cycles hold state with no timeout.
- CLASSIFY (exactly one cycle):
  - Compare the port against every enabled rule. The lowest matching index wins.
  - total_cnt is incremented. The winning channel's pkt_cnt is incremented, or miss_cnt if there is no match.
  - Session check on the winning channel: if its seen flag is 0 or the session is greater than the channel's last_sess, then sess_cnt is incremented, last_sess is set to the session, and seen is set to 1. Otherwise there is no change.
  - Afterwards the FSM returns to HUNT with the sync register cleared to 0.
  - Any bit presented during CLASSIFY is discarded.
- All counters saturate at all-ones and never wrap.
- Session comparison is unsigned 8-bit.
- Rule writes:
  - A write takes effect at the next edge.
  - Writing a rule clears that channel's seen flag and last_sess, but not its counters.
  - A write in the CLASSIFY cycle does not affect that classification (the old table is used).
- clr_cnt zeroes total, miss, pkt and sess counters. If clr_cnt coincides with CLASSIFY, the clear wins and the packet is not counted. pkt_done still pulses.
- Reset:
  - State goes to HUNT; sync register, bit counter and all counters go to 0.
  - All rules go to port 0 / disabled; all seen flags go to 0 and last_sess to 0.
  - pkt_done is 0, pkt_port is 0 and pkt_hit is 0.
  - Reset mid-packet abandons the capture with nothing counted.

## Timing
- Edge N samples the sync-completing bit; the FSM is in CAPTURE from edge N.
- Edge M samples packet bit PKT_BITS-1. CLASSIFY is the cycle from M to M+1.
- Counters, pkt_done, pkt_port and pkt_hit are updated at edge M+1.
- pkt_done is high for the single cycle after edge M+1.
- pkt_port and pkt_hit hold until the next classification or reset.
- With continuous valid data, a following sync word is detectable starting at the bit sampled at edge M+2.
- The earliest next packet_done is SYNC_W+PKT_BITS+1 cycles after the previous one.

## Test plan
- Reset, rule0 set to port 23399 and enabled, one packet with port 23399 and session 5 → at M+1: total_cnt=1, pkt_cnt[0]=1, sess_cnt[0]=1, pkt_hit=8'h01, and pkt_done pulses for 1 cycle.
- Rule2 and rule5 both set to port 22, packet with port 22 → only channel 2 counts, pkt_hit=8'h04. A packet with port 80 gives miss_cnt=1 and pkt_hit=0.
- Sessions 5, 5, 3, 9 on one channel → pkt_cnt=4, sess_cnt=2. After rewriting the rule, session 1 gives sess_cnt=3.
- CNT_W=8 and 260 hits on one channel → pkt_cnt=255 with no wrap, total_cnt=260.
- Sync embedded in the packet payload is not re-detected. Deasserting data_valid mid-packet for 10 cycles yields an identical result. rst asserted at bit 100 followed by a fresh packet → total_cnt=1.
- clr_cnt asserted in the CLASSIFY cycle → all counters 0 and pkt_done=1. A cfg write in the same CLASSIFY cycle uses the old rule for that packet.
